// File: rtl/lc3_operate_exec.sv
// lc3_operate_exec: multi-cycle execute/writeback stage for LC-3 ADD, AND and NOT
//   clock, reset_n        : clock, asynchronous active-low reset
//   instr_valid/ready     : decoder handshake, accepted only in IDLE
//   instr                 : instruction word
//   SR1, SR2 / SR1out, SR2out : register file read addresses / read data
//   DR, data, ld_reg      : register file write address, data, one-cycle strobe
//   nzp                   : condition codes {N,Z,P}
//   illegal               : one-cycle pulse after an unsupported opcode is offered
//   retired               : count of completed writebacks
module lc3_operate_exec #(
    parameter int READ_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    input  logic [15:0] SR1out,
    input  logic [15:0] SR2out,
    output logic [2:0]  DR,
    output logic [15:0] data,
    output logic        ld_reg,
    output logic [2:0]  nzp,
    output logic        illegal,
    output logic [15:0] retired
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
    state_t      state, state_nx;
    logic [15:0] ir, op_a, op_b, opnd_b, result;
    logic [2:0]  cnt;
    logic        accept, legal;
    assign accept = state == IDLE && instr_valid;
    assign legal  = instr[15:12] == 4'b0001 || instr[15:12] == 4'b0101 || instr[15:12] == 4'b1001;
    assign opnd_b = ir[5] ? {{11{ir[4]}}, ir[4:0]} : op_b;
    assign result = ir[15:12] == 4'b0001 ? op_a + opnd_b :
                    ir[15:12] == 4'b0101 ? op_a & opnd_b : ~op_a;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept && legal ? READ : IDLE;
            READ:    state_nx = cnt == 3'd1 ? EXEC : READ;
            EXEC:    state_nx = WB;
            default: state_nx = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            SR1         <= '0;
            SR2         <= '0;
            DR          <= '0;
            data        <= '0;
            ld_reg      <= 1'b0;
            illegal     <= 1'b0;
            nzp         <= 3'b010;
            retired     <= '0;
            ir          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nx;
            instr_ready <= state_nx == IDLE;
            ld_reg      <= state_nx == WB;
            illegal     <= accept && !legal;
            if (accept && legal) begin
                ir  <= instr;
                SR1 <= instr[8:6];
                SR2 <= instr[2:0];
                cnt <= 3'(READ_WAIT);
            end
            if (state == READ) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) begin
                    op_a <= SR1out;
                    op_b <= SR2out;
                end
            end
            if (state == EXEC) begin
                DR   <= ir[11:9];
                data <= result;
            end
            if (state == WB) begin
                nzp     <= {data[15], data == 16'd0, !data[15] && data != 16'd0};
                retired <= retired + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_lc3_operate_exec.sv
// tb_lc3_operate_exec: randomized self-checking bench with a register file and ISA-level reference model
module tb_lc3_operate_exec;
    localparam int RW  = 1;
    localparam int RW3 = 3;
    logic        clock = 1'b0, reset_n = 1'b0, instr_valid = 1'b0, v3 = 1'b0;
    logic [15:0] instr = '0;
    logic        rdy1, ld1, ill1, rdy3, ld3, ill3;
    logic [2:0]  sa1, sb1, dr1, nzp1, sa3, sb3, dr3, nzp3;
    logic [15:0] d1, ret1, d3, ret3;
    logic [15:0] rf [8];
    int          nvec = 0, nerr = 0;
    logic [2:0]  exp_nzp = 3'b010;
    logic [15:0] exp_ret = '0;

    always #5 clock = ~clock;

    lc3_operate_exec #(.READ_WAIT(RW)) u1 (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(rdy1),
        .instr(instr), .SR1(sa1), .SR2(sb1), .SR1out(rf[sa1]), .SR2out(rf[sb1]),
        .DR(dr1), .data(d1), .ld_reg(ld1), .nzp(nzp1), .illegal(ill1), .retired(ret1));
    lc3_operate_exec #(.READ_WAIT(RW3)) u3 (
        .clock(clock), .reset_n(reset_n), .instr_valid(v3), .instr_ready(rdy3),
        .instr(instr), .SR1(sa3), .SR2(sb3), .SR1out(rf[sa3]), .SR2out(rf[sb3]),
        .DR(dr3), .data(d3), .ld_reg(ld3), .nzp(nzp3), .illegal(ill3), .retired(ret3));

    function automatic logic [15:0] model(input logic [15:0] ins);
        int a, b;
        a = int'(rf[ins[8:6]]);
        b = ins[5] ? (ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0])) : int'(rf[ins[2:0]]);
        case (ins[15:12])
            4'b0001: return 16'((a + b) % 65536);
            4'b0101: return 16'(a) & 16'(b);
            default: return 16'(65535 - a);
        endcase
    endfunction

    function automatic logic [2:0] cc(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic run_instr(input logic [15:0] ins);
        logic [15:0] res;
        int n;
        res = model(ins);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        nvec++;
        if (rdy1 !== 1'b0 || sa1 !== ins[8:6] || sb1 !== ins[2:0]) begin
            nerr++;
            $display("FAIL read_addr ins=%h ready=%b SR1=%0d SR2=%0d, required ready=0 SR1=%0d SR2=%0d", ins, rdy1, sa1, sb1, ins[8:6], ins[2:0]);
        end
        n = 0;
        while (n < 20 && ld1 !== 1'b1) begin
            @(posedge clock); #1;
            n++;
        end
        nvec++;
        if (n != RW + 1 || dr1 !== ins[11:9] || d1 !== res || ill1 !== 1'b0) begin
            nerr++;
            $display("FAIL writeback ins=%h cycles=%0d DR=%0d data=%h illegal=%b, required cycles=%0d DR=%0d data=%h illegal=0", ins, n, dr1, d1, ill1, RW + 1, ins[11:9], res);
        end
        @(posedge clock); #1;
        exp_ret++;
        exp_nzp = cc(res);
        rf[ins[11:9]] = res;
        nvec++;
        if (ld1 !== 1'b0 || nzp1 !== exp_nzp || ret1 !== exp_ret || rdy1 !== 1'b1 || d1 !== res) begin
            nerr++;
            $display("FAIL post_wb ins=%h ld=%b nzp=%b retired=%0d ready=%b data=%h, required ld=0 nzp=%b retired=%0d ready=1 data=%h", ins, ld1, nzp1, ret1, rdy1, d1, exp_nzp, exp_ret, res);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        nvec++;
        if (rdy1 !== 1'b1 || sa1 !== 3'd0 || sb1 !== 3'd0 || dr1 !== 3'd0 || d1 !== 16'd0 ||
            ld1 !== 1'b0 || ill1 !== 1'b0 || nzp1 !== 3'b010 || ret1 !== 16'd0) begin
            nerr++;
            $display("FAIL reset ready=%b SR1=%0d SR2=%0d DR=%0d data=%h ld=%b ill=%b nzp=%b ret=%0d, required 1 0 0 0 0000 0 0 010 0", rdy1, sa1, sb1, dr1, d1, ld1, ill1, nzp1, ret1);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed;
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
        rf[1] = 16'h0005;
        rf[2] = 16'hFFFD;
        run_instr(16'h1642);
        run_instr(16'h5860);
        run_instr(16'h9A7F);
        run_instr(16'h1C70);
    endtask

    task automatic test_read_wait;
        logic [15:0] res;
        int n1, n3;
        rf[1] = 16'h0005;
        res = model(16'h1C70);
        instr = 16'h1C70;
        instr_valid = 1'b1;
        v3 = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        v3 = 1'b0;
        n1 = -1;
        n3 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (ld1 === 1'b1 && n1 < 0) n1 = c;
            if (ld3 === 1'b1 && n3 < 0) n3 = c;
        end
        exp_ret++;
        exp_nzp = cc(res);
        rf[6] = res;
        nvec++;
        if (n1 != RW + 1 || n3 != RW3 + 1 || n3 - n1 != 2 || d3 !== res || dr3 !== 3'd6 || nzp3 !== 3'b100) begin
            nerr++;
            $display("FAIL read_wait ld1_cycle=%0d ld3_cycle=%0d data3=%h DR3=%0d nzp3=%b, required %0d %0d %h 6 100", n1, n3, d3, dr3, nzp3, RW + 1, RW3 + 1, res);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] op;
        for (int k = 0; k < 6; k++) begin
            op = 4'($urandom_range(0, 15));
            while (op == 4'b0001 || op == 4'b0101 || op == 4'b1001) op = 4'($urandom_range(0, 15));
            instr = k == 0 ? 16'h0000 : {op, 12'($urandom)};
            instr_valid = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(posedge clock); #1;
                nvec++;
                if (ill1 !== 1'b1 || ld1 !== 1'b0 || rdy1 !== 1'b1 || nzp1 !== exp_nzp || ret1 !== exp_ret) begin
                    nerr++;
                    $display("FAIL illegal ins=%h ill=%b ld=%b ready=%b nzp=%b ret=%0d, required 1 0 1 %b %0d", instr, ill1, ld1, rdy1, nzp1, ret1, exp_nzp, exp_ret);
                end
            end
            instr_valid = 1'b0;
            @(posedge clock); #1;
            nvec++;
            if (ill1 !== 1'b0) begin
                nerr++;
                $display("FAIL illegal_drop ill=%b, required 0", ill1);
            end
        end
    endtask

    task automatic test_back_to_back;
        localparam int P = RW + 3;
        logic [15:0] res;
        int pulses;
        res = model(16'h1642);
        pulses = 0;
        instr = 16'h1642;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        for (int c = 0; c < 3 * P; c++) begin
            nvec++;
            if (ld1 !== (c % P == RW + 1) || rdy1 !== (c % P == RW + 2) || (ld1 === 1'b1 && d1 !== res)) begin
                nerr++;
                $display("FAIL back_to_back cycle=%0d ld=%b ready=%b data=%h, required ld=%b ready=%b data=%h", c, ld1, rdy1, d1, c % P == RW + 1, c % P == RW + 2, res);
            end
            if (ld1 === 1'b1) pulses++;
            if (c == 3 * P - 1) instr_valid = 1'b0;
            else begin
                @(posedge clock); #1;
            end
        end
        exp_ret += 16'(pulses);
        exp_nzp = cc(res);
        rf[3] = res;
        @(posedge clock); #1;
        nvec++;
        if (pulses != 3 || ret1 !== exp_ret || nzp1 !== exp_nzp || rdy1 !== 1'b1) begin
            nerr++;
            $display("FAIL back_to_back_end pulses=%0d ret=%0d nzp=%b ready=%b, required 3 %0d %b 1", pulses, ret1, nzp1, rdy1, exp_ret, exp_nzp);
        end
    endtask

    task automatic test_random;
        logic [15:0] ins;
        logic [3:0] ops [3];
        ops[0] = 4'b0001;
        ops[1] = 4'b0101;
        ops[2] = 4'b1001;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            if (k % 5 == 0) rf[$urandom_range(0, 7)] = 16'h0000;
            ins = 16'($urandom);
            ins[15:12] = ops[$urandom_range(0, 2)];
            run_instr(ins);
        end
    endtask

    task automatic test_reset_wb;
        int n;
        rf[1] = 16'h0005;
        rf[2] = 16'hFFFD;
        instr = 16'h1642;
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        n = 0;
        while (n < 20 && ld1 !== 1'b1) begin
            @(posedge clock); #1;
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        nvec++;
        if (n >= 20 || ld1 !== 1'b0 || nzp1 !== 3'b010 || ret1 !== 16'd0 || rdy1 !== 1'b1) begin
            nerr++;
            $display("FAIL reset_in_wb wait=%0d ld=%b nzp=%b ret=%0d ready=%b, required ld=0 nzp=010 ret=0 ready=1", n, ld1, nzp1, ret1, rdy1);
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        exp_ret = '0;
        exp_nzp = 3'b010;
        @(posedge clock); #1;
        run_instr(16'h1642);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_read_wait;
        test_illegal;
        test_back_to_back;
        test_random;
        test_reset_wb;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
